// File: rtl/alu_share_arbiter.sv
// Arbitrates two requesters onto the shared 8-bit ALU; ALU_ARB_RR_EN selects round robin over fixed priority.
// Latency: accept at edge T, operands registered after T, response registered after T+1.
// Backpressure: no request is accepted while a response waits on rsp_ready.
module alu_share_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [2:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [2:0] req1_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_y,
  input  logic       alu_c,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic       alu_v,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_y,
  output logic       rsp_c,
  output logic       rsp_z,
  output logic       rsp_n,
  output logic       rsp_v
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t state, state_nxt;
  logic   can_accept;
  logic   pick1;
  logic   hs;

`ifdef ALU_ARB_RR_EN
  // Remembers the last granted port; starts at 1 so port 0 wins first.
  logic last_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant <= 1'b1;
    else if (hs) last_grant <= pick1;
  end

  assign pick1 = req1_valid & (~req0_valid | ~last_grant);
`else
  assign pick1 = req1_valid & ~req0_valid;
`endif

  assign can_accept = ~rst & ((state == IDLE) | ((state == RESP) & rsp_ready));
  assign req0_ready = can_accept & req0_valid & ~pick1;
  assign req1_ready = can_accept & pick1;
  assign hs         = req0_ready | req1_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = hs ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a     <= 8'h00;
      alu_b     <= 8'h00;
      alu_op    <= 3'd0;
      rsp_id    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_y     <= 8'h00;
      rsp_c     <= 1'b0;
      rsp_z     <= 1'b0;
      rsp_n     <= 1'b0;
      rsp_v     <= 1'b0;
    end else begin
      if (hs) begin
        alu_a  <= pick1 ? req1_a  : req0_a;
        alu_b  <= pick1 ? req1_b  : req0_b;
        alu_op <= pick1 ? req1_op : req0_op;
        rsp_id <= pick1;
      end
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_y     <= alu_y;
        rsp_c     <= alu_c;
        rsp_z     <= alu_z;
        rsp_n     <= alu_n;
        rsp_v     <= alu_v;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a behavioural ALU plus a response scoreboard.
module tb_alu_share_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0] req0_op = '0, req1_op = '0;
  logic [7:0] alu_a, alu_b, alu_y;
  logic [2:0] alu_op;
  logic       alu_c, alu_z, alu_n, alu_v;
  logic       rsp_valid, rsp_ready = 1'b0, rsp_id;
  logic [7:0] rsp_y;
  logic       rsp_c, rsp_z, rsp_n, rsp_v;

  int checks = 0;
  int errors = 0;

  logic [2:0]  rop[2];
  logic [7:0]  ra[2], rb[2];
  logic [12:0] expq[$];

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_c(rsp_c), .rsp_z(rsp_z), .rsp_n(rsp_n), .rsp_v(rsp_v)
  );

  // 6502-style ALU: {y, c, z, n, v}; opcode 7 returns a fixed default pattern.
  function automatic logic [11:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] y;
    logic       c, v;
    s = '0; y = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; y = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (y[7] != a[7]); end
      3'd1: begin y = a - b; c = (a >= b); v = (a[7] != b[7]) && (y[7] != a[7]); end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: begin y = {a[6:0], 1'b0}; c = a[7]; end
      3'd6: begin y = {1'b0, a[7:1]}; c = a[0]; end
      default: begin y = 8'h5A; c = 1'b1; v = 1'b1; end
    endcase
    return {y, c, (y == 8'h00), y[7], v};
  endfunction

  assign {alu_y, alu_c, alu_z, alu_n, alu_v} = alu_ref(alu_op, alu_a, alu_b);

  function automatic logic [12:0] obs();
    return {rsp_id, rsp_y, rsp_c, rsp_z, rsp_n, rsp_v};
  endfunction

  task automatic set_port(input int p, input logic v);
    if (p == 0) begin req0_valid = v; req0_op = rop[0]; req0_a = ra[0]; req0_b = rb[0]; end
    else        begin req1_valid = v; req1_op = rop[1]; req1_a = ra[1]; req1_b = rb[1]; end
  endtask

  task automatic randomize_port(input int p);
    rop[p] = 3'($urandom_range(0, 7));
    ra[p]  = 8'($urandom);
    rb[p]  = 8'($urandom);
  endtask

  // Presents one request and returns just after the handshake edge.
  task automatic send(input int p, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, output bit ok);
    ok = 1'b0;
    rop[p] = op; ra[p] = a; rb[p] = b;
    set_port(p, 1'b1);
    for (int i = 0; i < 32 && !ok; i++) begin
      @(negedge clk);
      if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) ok = 1'b1;
      @(posedge clk);
    end
    #1 set_port(p, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #3;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
    checks++;
    if ({rsp_valid, rsp_id, rsp_y, rsp_c, rsp_z, rsp_n, rsp_v} !== 14'h0) begin errors++; $display("FAIL reset_rsp: got valid=%b %h expected all zero", rsp_valid, obs()); end
    checks++;
    if ({alu_a, alu_b, alu_op} !== 19'h0) begin errors++; $display("FAIL reset_alu: got %h %h %h expected 0", alu_a, alu_b, alu_op); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add_port0();
    bit ok;
    rsp_ready = 1'b1;
    send(0, 3'd0, 8'h50, 8'h50, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL add_grant: got no ready expected handshake"); end
    @(negedge clk);
    checks++;
    if ({rsp_valid, alu_a, alu_b, alu_op} !== {1'b0, 8'h50, 8'h50, 3'd0}) begin
      errors++; $display("FAIL add_exec: got v=%b a=%h b=%h op=%0d expected v=0 a=50 b=50 op=0", rsp_valid, alu_a, alu_b, alu_op);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_y, rsp_z, rsp_n, rsp_v} !== {1'b1, 1'b0, 8'hA0, 1'b0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL add_rsp: got v=%b id=%b y=%h z=%b n=%b v=%b expected v=1 id=0 y=a0 z=0 n=1 v=1", rsp_valid, rsp_id, rsp_y, rsp_z, rsp_n, rsp_v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_sub_port1();
    bit ok;
    rsp_ready = 1'b1;
    send(1, 3'd1, 8'h33, 8'h33, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL sub_grant: got no ready expected handshake"); end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_y, rsp_z, rsp_n} !== {1'b1, 1'b1, 8'h00, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sub_rsp: got v=%b id=%b y=%h z=%b n=%b expected v=1 id=1 y=00 z=1 n=0", rsp_valid, rsp_id, rsp_y, rsp_z, rsp_n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_contention();
    int grants, rsps, prev_g, g, exp_g;
    logic [12:0] e;
    do_reset();
    expq.delete();
    rsp_ready = 1'b1;
    randomize_port(0); randomize_port(1);
    set_port(0, 1'b1); set_port(1, 1'b1);
    grants = 0; rsps = 0; prev_g = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      g = -1;
      if (req0_ready && req1_ready) begin checks++; errors++; $display("FAIL both_ready: got 11 expected one-hot at cycle %0d", i); end
      else if (req0_ready) g = 0;
      else if (req1_ready) g = 1;
      if (rsp_valid) begin
        rsps++;
        e = (expq.size() != 0) ? expq.pop_front() : 13'h1FFF;
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL contention_rsp: got %h expected %h", obs(), e); end
      end
      if (g >= 0) begin
`ifdef ALU_ARB_RR_EN
        exp_g = (prev_g < 0) ? 0 : 1 - prev_g;
`else
        exp_g = 0;
`endif
        checks++;
        if (g != exp_g) begin errors++; $display("FAIL contention_grant: got port %0d expected port %0d", g, exp_g); end
        grants++;
        prev_g = g;
        expq.push_back({g[0], alu_ref(rop[g], ra[g], rb[g])});
      end
      @(posedge clk);
      #1;
      if (g >= 0) begin randomize_port(g); set_port(g, 1'b1); end
    end
    checks++;
    if (grants != 10 || rsps != 9) begin errors++; $display("FAIL contention_rate: got %0d grants %0d rsps expected 10 grants 9 rsps", grants, rsps); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 8 && expq.size() != 0; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        e = expq.pop_front();
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL contention_drain: got %h expected %h", obs(), e); end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (expq.size() != 0) begin errors++; $display("FAIL contention_timeout: got %0d pending expected 0", expq.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    rsp_ready = 1'b0;
    send(0, 3'd2, 8'hF0, 8'h3C, ok);
    rop[1] = 3'd5; ra[1] = 8'h81; rb[1] = 8'h00;
    set_port(1, 1'b1);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL and_grant: got no ready expected handshake"); end
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL exec_ready: got %b expected 00", {req0_ready, req1_ready}); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_y, req0_ready, req1_ready} !== {1'b1, 8'h30, 2'b00}) begin
        errors++; $display("FAIL hold_rsp: got v=%b y=%h rdy=%b%b expected v=1 y=30 rdy=00", rsp_valid, rsp_y, req0_ready, req1_ready);
      end
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, req1_ready} !== 2'b11) begin errors++; $display("FAIL b2b_ready: got v=%b rdy1=%b expected 11", rsp_valid, req1_ready); end
    @(posedge clk);
    #1 set_port(1, 1'b0);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_clear: got %b expected 0", rsp_valid); end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_y, rsp_c} !== {1'b1, 1'b1, 8'h02, 1'b1}) begin
      errors++; $display("FAIL shl_rsp: got v=%b id=%b y=%h c=%b expected v=1 id=1 y=02 c=1", rsp_valid, rsp_id, rsp_y, rsp_c);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    for (int variant = 0; variant < 2; variant++) begin
      rsp_ready = 1'b0;
      send(0, 3'd4, 8'($urandom), 8'($urandom), ok);
      repeat (variant) @(posedge clk);
      #2 rst = 1'b1;
      rop[1] = 3'd0; ra[1] = 8'h11; rb[1] = 8'h22;
      set_port(1, 1'b1);
      #1;
      checks++;
      if ({rsp_valid, req1_ready, alu_a} !== {1'b0, 1'b0, 8'h00}) begin
        errors++; $display("FAIL midreset_%0d: got v=%b rdy1=%b alu_a=%h expected 0 0 00", variant, rsp_valid, req1_ready, alu_a);
      end
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      set_port(1, 1'b0);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stale_rsp: got %b expected 0", rsp_valid); end
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      rop[0] = 3'd0; ra[0] = 8'h01; rb[0] = 8'h02;
      set_port(0, 1'b1); set_port(1, 1'b1);
      @(negedge clk);
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL post_reset_grant: got %b expected 10", {req0_ready, req1_ready}); end
      @(posedge clk);
      #1 set_port(0, 1'b0); set_port(1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 1'b0, 8'h03}) begin
        errors++; $display("FAIL post_reset_rsp: got v=%b id=%b y=%h expected 1 0 03", rsp_valid, rsp_id, rsp_y);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_op7();
    bit ok;
    rsp_ready = 1'b1;
    send(1, 3'd7, 8'h12, 8'h34, ok);
    @(negedge clk);
    checks++;
    if ({ok, alu_op} !== {1'b1, 3'd7}) begin errors++; $display("FAIL op7_issue: got ok=%b op=%0d expected ok=1 op=7", ok, alu_op); end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_y, rsp_c, rsp_v} !== {1'b1, 1'b1, 8'h5A, 1'b1, 1'b1}) begin
      errors++; $display("FAIL op7_rsp: got v=%b id=%b y=%h c=%b v=%b expected 1 1 5a 1 1", rsp_valid, rsp_id, rsp_y, rsp_c, rsp_v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    bit pend[2];
    bit prev_hold;
    int last, g, exp_g;
    logic [12:0] prev_obs, e;
    do_reset();
    expq.delete();
    pend[0] = 1'b0; pend[1] = 1'b0;
    prev_hold = 1'b0; prev_obs = '0; last = 1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin randomize_port(p); pend[p] = 1'b1; end
        set_port(p, pend[p]);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (prev_hold) begin
        checks++;
        if ({rsp_valid, obs()} !== {1'b1, prev_obs}) begin errors++; $display("FAIL rsp_stable: got v=%b %h expected v=1 %h", rsp_valid, obs(), prev_obs); end
      end
      checks++;
      if ((req0_ready && (req1_ready || !req0_valid)) || (req1_ready && !req1_valid) ||
          ((req0_ready || req1_ready) && rsp_valid && !rsp_ready)) begin
        errors++; $display("FAIL ready_rule: got rdy=%b%b vld=%b%b rsp=%b%b expected legal grant", req0_ready, req1_ready, req0_valid, req1_valid, rsp_valid, rsp_ready);
      end
      if (rsp_valid && rsp_ready) begin
        e = (expq.size() != 0) ? expq.pop_front() : 13'h1FFF;
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL random_rsp: got %h expected %h", obs(), e); end
      end
      g = req0_ready ? 0 : (req1_ready ? 1 : -1);
      if (g >= 0) begin
        if (pend[0] && pend[1]) begin
`ifdef ALU_ARB_RR_EN
          exp_g = 1 - last;
`else
          exp_g = 0;
`endif
          checks++;
          if (g != exp_g) begin errors++; $display("FAIL random_arb: got port %0d expected port %0d", g, exp_g); end
        end
        expq.push_back({g[0], alu_ref(rop[g], ra[g], rb[g])});
        last = g;
        pend[g] = 1'b0;
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_obs = obs();
      @(posedge clk);
      #1;
    end
    set_port(0, 1'b0); set_port(1, 1'b0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 8 && expq.size() != 0; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        e = expq.pop_front();
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL random_drain: got %h expected %h", obs(), e); end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (expq.size() != 0) begin errors++; $display("FAIL random_timeout: got %0d pending expected 0", expq.size()); end
  endtask

  initial begin
    test_reset();
    test_add_port0();
    test_sub_port1();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_op7();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
